// File: rtl/rgb_mixer_core.sv
// Three-channel RGB mixer: quadrature encoders set 8-bit levels that drive per-channel PWM outputs.
// Optional debounce on the encoder phases is built when RGB_MIXER_DEBOUNCE_EN is defined.

module rgb_mixer_lane #(
  parameter int WIDTH    = 8,
  parameter int DEB_HIST = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_pin,
  input  logic             b_pin,
  input  logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] level,
  output logic             pwm_out
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0] sync_a, sync_b;
  logic       clean_a, clean_b;
  logic       a_q, b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[0], a_pin};
      sync_b <= {sync_b[0], b_pin};
    end
  end

`ifdef RGB_MIXER_DEBOUNCE_EN
  logic [DEB_HIST-1:0] hist_a, hist_b;

  // clean phase only moves once the whole history window agrees
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_a  <= '0;
      hist_b  <= '0;
      clean_a <= 1'b0;
      clean_b <= 1'b0;
    end else begin
      hist_a <= {hist_a[DEB_HIST-2:0], sync_a[1]};
      hist_b <= {hist_b[DEB_HIST-2:0], sync_b[1]};
      if (&hist_a)       clean_a <= 1'b1;
      else if (~|hist_a) clean_a <= 1'b0;
      if (&hist_b)       clean_b <= 1'b1;
      else if (~|hist_b) clean_b <= 1'b0;
    end
  end
`else
  assign clean_a = sync_a[1];
  assign clean_b = sync_b[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      level   <= '0;
      pwm_out <= 1'b0;
    end else begin
      a_q <= clean_a;
      b_q <= clean_b;
      // half-step decode: a edge with b steady low/high counts up, b edge counts down
      case ({clean_a, a_q, clean_b, b_q})
        4'b1000, 4'b0111: level <= level + ONE;
        4'b0010, 4'b1101: level <= level - ONE;
        default: ;
      endcase
      pwm_out <= (cnt < level);
    end
  end
endmodule

module rgb_mixer_core #(
  parameter int WIDTH    = 8,
  parameter int DEB_HIST = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enc0_a,
  input  logic enc0_b,
  input  logic enc1_a,
  input  logic enc1_b,
  input  logic enc2_a,
  input  logic enc2_b,
  output logic pwm0_out,
  output logic pwm1_out,
  output logic pwm2_out
);
  localparam int NUM_LANES = 3;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [NUM_LANES-1:0]            a_pins, b_pins, pwm;
  logic [NUM_LANES-1:0][WIDTH-1:0] level;
  logic [WIDTH-1:0]                cnt;

  assign a_pins = {enc2_a, enc1_a, enc0_a};
  assign b_pins = {enc2_b, enc1_b, enc0_b};
  assign {pwm2_out, pwm1_out, pwm0_out} = pwm;

  // one shared counter keeps all channels phase-aligned
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + ONE;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rgb_mixer_lane #(.WIDTH(WIDTH), .DEB_HIST(DEB_HIST)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .a_pin   (a_pins[i]),
      .b_pin   (b_pins[i]),
      .cnt     (cnt),
      .level   (level[i]),
      .pwm_out (pwm[i])
    );
  end
endmodule

// File: tb/tb_rgb_mixer_core.sv
// Randomized + directed bench for rgb_mixer_core against a sample-history reference model.
module tb_rgb_mixer_core;
  localparam int WIDTH    = 8;
  localparam int DEB_HIST = 8;
  localparam int MODV     = 1 << WIDTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] pa = '0, pb = '0;
  logic pwm0, pwm1, pwm2;

  always #5 clk = ~clk;

  rgb_mixer_core #(.WIDTH(WIDTH), .DEB_HIST(DEB_HIST)) dut (
    .clk(clk), .reset(reset),
    .enc0_a(pa[0]), .enc0_b(pb[0]),
    .enc1_a(pa[1]), .enc1_b(pb[1]),
    .enc2_a(pa[2]), .enc2_b(pb[2]),
    .pwm0_out(pwm0), .pwm1_out(pwm1), .pwm2_out(pwm2)
  );

  int errors = 0, checks = 0;
  bit started = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int  m_level [3];
  int  m_cnt;
  bit  m_pwm [3];
  bit [1:0] samp [3][16];   // {a,b} pin samples, index 0 = most recent edge
  bit [1:0] cl1 [3], cl2 [3]; // clean phases one and two cycles back

  function automatic int dec(input bit [1:0] now, input bit [1:0] old);
    if ( now[1] && !old[1] && !now[0] && !old[0]) return  1;
    if (!now[1] &&  old[1] &&  now[0] &&  old[0]) return  1;
    if (!now[1] && !old[1] &&  now[0] && !old[0]) return -1;
    if ( now[1] &&  old[1] && !now[0] &&  old[0]) return -1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0;
      for (int c = 0; c < 3; c++) begin
        m_level[c] = 0; m_pwm[c] = 0; cl1[c] = 0; cl2[c] = 0;
        for (int k = 0; k < 16; k++) samp[c][k] = 0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        bit [1:0] nc;
        m_pwm[c]   = (m_cnt < m_level[c]);
        m_level[c] = (m_level[c] + MODV + dec(cl1[c], cl2[c])) % MODV;
        for (int k = 15; k > 0; k--) samp[c][k] = samp[c][k-1];
        samp[c][0] = {pa[c], pb[c]};
`ifdef RGB_MIXER_DEBOUNCE_EN
        for (int p = 0; p < 2; p++) begin
          bit all1 = 1, all0 = 1;
          for (int k = 3; k < DEB_HIST + 3; k++)
            if (samp[c][k][p]) all0 = 0; else all1 = 0;
          nc[p] = all1 ? 1'b1 : (all0 ? 1'b0 : cl1[c][p]);
        end
`else
        nc = samp[c][1];
`endif
        cl2[c] = cl1[c];
        cl1[c] = nc;
      end
      m_cnt = (m_cnt + 1) % MODV;
    end
  end

  // every-cycle comparison of outputs and levels
  always @(negedge clk) begin
    if (started) begin
      check("pwm0", int'(pwm0), int'(m_pwm[0]));
      check("pwm1", int'(pwm1), int'(m_pwm[1]));
      check("pwm2", int'(pwm2), int'(m_pwm[2]));
      for (int c = 0; c < 3; c++) check("level", int'(dut.level[c]), m_level[c]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit [2:0] mask, input bit cw);
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++)
        if (mask[c]) begin
          if ((ph == 0) == cw) pa[c] = ~pa[c];
          else                 pb[c] = ~pb[c];
        end
      repeat (20) @(negedge clk);
    end
  endtask

  initial begin
    int hi0, hi1, hi2, skew;
    repeat (2) @(negedge clk);
    started = 1;
    repeat (3) @(negedge clk);
    reset = 0;

    hi0 = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      hi0 += int'(pwm0 | pwm1 | pwm2);
    end
    check("idle_pwm_highs", hi0, 0);
    for (int c = 0; c < 3; c++) check("idle_level", int'(dut.level[c]), 0);

    repeat (10) step(3'b001, 1'b1);
    check("cw10_level0", int'(dut.level[0]), 10);
    check("cw10_model0", m_level[0], 10);
    hi0 = 0; hi1 = 0; hi2 = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi0 += int'(pwm0); hi1 += int'(pwm1); hi2 += int'(pwm2);
    end
    check("cw10_pwm0_highs", hi0, 10);
    check("cw10_pwm1_highs", hi1, 0);
    check("cw10_pwm2_highs", hi2, 0);

    step(3'b010, 1'b0);
    check("ccw_wrap_level1", int'(dut.level[1]), 255);
    step(3'b010, 1'b1);
    check("cw_wrap_level1", int'(dut.level[1]), 0);

    @(negedge clk) pa[2] = 1'b1;
    repeat (3) @(negedge clk);
    pa[2] = 1'b0;
    repeat (40) @(negedge clk);
`ifdef RGB_MIXER_DEBOUNCE_EN
    check("glitch_level2", int'(dut.level[2]), 0);
`else
    // a single-phase pulse is a rising then falling edge; only one of them is a counting pattern
    check("glitch_level2", int'(dut.level[2]), m_level[2]);
`endif

    repeat (300) begin
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 2) == 0) begin
          pa[c] = 1'($urandom);
          pb[c] = 1'($urandom);
        end
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    pa = '0; pb = '0;
    repeat (40) @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    for (int c = 0; c < 3; c++) check("post_reset_level", int'(dut.level[c]), 0);

    repeat (128) step(3'b111, 1'b1);
    for (int c = 0; c < 3; c++) check("all128_level", int'(dut.level[c]), 128);
    hi0 = 0; hi1 = 0; hi2 = 0; skew = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi0 += int'(pwm0); hi1 += int'(pwm1); hi2 += int'(pwm2);
      if (pwm0 != pwm1 || pwm1 != pwm2) skew++;
    end
    check("all128_pwm0_highs", hi0, 128);
    check("all128_pwm1_highs", hi1, 128);
    check("all128_pwm2_highs", hi2, 128);
    check("all128_phase_skew", skew, 0);

    repeat (72) step(3'b001, 1'b1);
    check("level0_200", int'(dut.level[0]), 200);
    repeat (37) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("midreset_level0", int'(dut.level[0]), 0);
    check("midreset_pwm0", int'(pwm0), 0);
    check("midreset_cnt", int'(dut.cnt), 0);
    reset = 0;
    repeat (10) @(negedge clk);

    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
